// File: rtl/blit_pkg.sv
// Shared types, default geometry and helpers for the sprite blitter.
package blit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } blit_state_e;

  localparam int unsigned DefSpriteW        = 21;
  localparam int unsigned DefSpriteH        = 45;
  localparam int unsigned DefFbW            = 320;
  localparam int unsigned DefFbH            = 240;
  localparam int unsigned DefIdxW           = 5;
  localparam int unsigned DefRomAw          = 11;
  localparam int unsigned DefFbAw           = 17;
  localparam int unsigned DefTransparentIdx = 0;

  // Multiply by a constant as an explicit shift-and-add chain.
  function automatic logic [31:0] mul_const(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) res = res + (a << i);
    end
    return res;
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Control, sprite ROM and frame-buffer write bundle of the sprite blitter.
// BLIT_MIRROR_EN adds the mirror_x request bit.
interface sprite_blitter_if
  import blit_pkg::*;
#(
  parameter int unsigned IDX_W  = DefIdxW,
  parameter int unsigned ROM_AW = DefRomAw,
  parameter int unsigned FB_AW  = DefFbAw
);
  logic              start;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
`ifdef BLIT_MIRROR_EN
  logic              mirror_x;
`endif
  logic [ROM_AW-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [IDX_W-1:0]  fb_data;
  logic              busy;
  logic              done;

`ifdef BLIT_MIRROR_EN
  modport master (
    output start, pos_x, pos_y, mirror_x, rom_q,
    input  rom_address, fb_we, fb_addr, fb_data, busy, done
  );
  modport slave (
    input  start, pos_x, pos_y, mirror_x, rom_q,
    output rom_address, fb_we, fb_addr, fb_data, busy, done
  );
`else
  modport master (
    output start, pos_x, pos_y, rom_q,
    input  rom_address, fb_we, fb_addr, fb_data, busy, done
  );
  modport slave (
    input  start, pos_x, pos_y, rom_q,
    output rom_address, fb_we, fb_addr, fb_data, busy, done
  );
`endif
endinterface

// File: rtl/blit_addr_gen.sv
// Column/row walker with incremental ROM and frame-buffer row bases.
// Produces the ROM address and frame-buffer address of the current pixel.
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int unsigned SPRITE_W = DefSpriteW,
  parameter int unsigned SPRITE_H = DefSpriteH,
  parameter int unsigned FB_W     = DefFbW,
  parameter int unsigned ROM_AW   = DefRomAw,
  parameter int unsigned FB_AW    = DefFbAw
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [9:0]        pos_x_i,
  input  logic [9:0]        pos_y_i,
  input  logic              mirror_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [FB_AW-1:0]  fb_addr_o,
  output logic [10:0]       x_o,
  output logic [10:0]       y_o,
  output logic              last_o
);
  localparam int unsigned ColW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned RowW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ROM_AW-1:0] rom_base_q, rom_base_d;
  logic [FB_AW-1:0]  fb_base_q, fb_base_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [10:0]       y_q, y_d;
  logic              mirror_q, mirror_d;
  logic [ColW-1:0]   rom_col;
  logic              col_end;

  // Current pixel addresses; the ROM column may be flipped, the screen column never is.
  always_comb begin
    col_end    = (col_q == ColW'(SPRITE_W - 1));
    rom_col    = mirror_q ? (ColW'(SPRITE_W - 1) - col_q) : col_q;
    x_o        = {1'b0, pos_x_q} + 11'(col_q);
    y_o        = y_q;
    rom_addr_o = rom_base_q + ROM_AW'(rom_col);
    fb_addr_o  = fb_base_q + FB_AW'(x_o);
    last_o     = col_end && (row_q == RowW'(SPRITE_H - 1));
  end

  // Counter and row-base accumulator update.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    rom_base_d = rom_base_q;
    fb_base_d  = fb_base_q;
    pos_x_d    = pos_x_q;
    y_d        = y_q;
    mirror_d   = mirror_q;
    if (load_i) begin
      col_d      = '0;
      row_d      = '0;
      rom_base_d = '0;
      fb_base_d  = FB_AW'(mul_const(32'(pos_y_i), 32'(FB_W)));
      pos_x_d    = pos_x_i;
      y_d        = {1'b0, pos_y_i};
      mirror_d   = mirror_i;
    end else if (step_i) begin
      if (col_end) begin
        col_d      = '0;
        row_d      = row_q + 1'b1;
        rom_base_d = rom_base_q + ROM_AW'(SPRITE_W);
        fb_base_d  = fb_base_q + FB_AW'(FB_W);
        y_d        = y_q + 11'd1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Walker state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q      <= '0;
      row_q      <= '0;
      rom_base_q <= '0;
      fb_base_q  <= '0;
      pos_x_q    <= '0;
      y_q        <= '0;
      mirror_q   <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      rom_base_q <= rom_base_d;
      fb_base_q  <= fb_base_d;
      pos_x_q    <= pos_x_d;
      y_q        <= y_d;
      mirror_q   <= mirror_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: FSM, two-stage pixel pipeline alongside the ROM read,
// clipping/transparency and registered frame-buffer write port.
// BLIT_MIRROR_EN enables the horizontal flip through bus.mirror_x.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int unsigned SPRITE_W        = DefSpriteW,
  parameter int unsigned SPRITE_H        = DefSpriteH,
  parameter int unsigned FB_W            = DefFbW,
  parameter int unsigned FB_H            = DefFbH,
  parameter int unsigned IDX_W           = DefIdxW,
  parameter int unsigned ROM_AW          = DefRomAw,
  parameter int unsigned FB_AW           = DefFbAw,
  parameter int unsigned TRANSPARENT_IDX = DefTransparentIdx
) (
  input logic             vga_clk,
  input logic             reset,
  sprite_blitter_if.slave bus
);
  blit_state_e       state_q, state_d;
  logic              drain_q, drain_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [FB_AW-1:0]  s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic              s1_in_q, s1_in_d, s2_in_q, s2_in_d;
  logic [ROM_AW-1:0] rom_address_q, rom_address_d;
  logic              fb_we_q, fb_we_d;
  logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
  logic [IDX_W-1:0]  fb_data_q, fb_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              load, step, ag_last, mirror;
  logic [ROM_AW-1:0] ag_rom_addr;
  logic [FB_AW-1:0]  ag_fb_addr;
  logic [10:0]       ag_x, ag_y;

`ifdef BLIT_MIRROR_EN
  assign mirror = bus.mirror_x;
`else
  assign mirror = 1'b0;
`endif

  blit_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .FB_W     (FB_W),
    .ROM_AW   (ROM_AW),
    .FB_AW    (FB_AW)
  ) u_addr_gen (
    .clk_i      (vga_clk),
    .rst_i      (reset),
    .load_i     (load),
    .step_i     (step),
    .pos_x_i    (bus.pos_x),
    .pos_y_i    (bus.pos_y),
    .mirror_i   (mirror),
    .rom_addr_o (ag_rom_addr),
    .fb_addr_o  (ag_fb_addr),
    .x_o        (ag_x),
    .y_o        (ag_y),
    .last_o     (ag_last)
  );

  // Next-state, pipeline and output-register logic.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    rom_address_d = rom_address_q;
    load          = 1'b0;
    step          = 1'b0;
    v1_d          = 1'b0;
    done_d        = 1'b0;
    s1_addr_d     = ag_fb_addr;
    s1_in_d       = (ag_x < 11'(FB_W)) && (ag_y < 11'(FB_H));
    v2_d          = v1_q;
    s2_addr_d     = s1_addr_q;
    s2_in_d       = s1_in_q;
    fb_we_d       = v2_q && s2_in_q && (bus.rom_q != IDX_W'(TRANSPARENT_IDX));
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    if (v2_q) begin
      fb_addr_d = s2_addr_q;
      fb_data_d = bus.rom_q;
    end
    busy_d = (state_q == StRun) || (state_q == StDrain);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step          = 1'b1;
        v1_d          = 1'b1;
        rom_address_d = ag_rom_addr;
        if (ag_last) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end
      end
      StDrain: begin
        if (drain_q) state_d = StDone;
        else         drain_d = 1'b1;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, pipeline valids and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q       <= StIdle;
      drain_q       <= 1'b0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      s1_addr_q     <= '0;
      s2_addr_q     <= '0;
      s1_in_q       <= 1'b0;
      s2_in_q       <= 1'b0;
      rom_address_q <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      s1_addr_q     <= s1_addr_d;
      s2_addr_q     <= s2_addr_d;
      s1_in_q       <= s1_in_d;
      s2_in_q       <= s2_in_d;
      rom_address_q <= rom_address_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.rom_address = rom_address_q;
  assign bus.fb_we       = fb_we_q;
  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_data     = fb_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: vector table, randomized blits against
// a pixel-list reference model, and held-start / mid-run reset sequences.
module tb_sprite_blitter;
  import blit_pkg::*;

  localparam int W   = 21;
  localparam int H   = 45;
  localparam int N   = W * H;
  localparam int FBW = 320;
  localparam int FBH = 240;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  sprite_blitter_if #(.IDX_W(5), .ROM_AW(11), .FB_AW(17)) bus ();

  sprite_blitter #(
    .SPRITE_W(W), .SPRITE_H(H), .FB_W(FBW), .FB_H(FBH), .IDX_W(5),
    .ROM_AW(11), .FB_AW(17), .TRANSPARENT_IDX(0)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous sprite ROM: data one cycle after address.
  logic [4:0] rom_mem [0:2047];
  always @(posedge vga_clk) bus.rom_q <= rom_mem[bus.rom_address];

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int px;
    int py;
    int mode;
    int exp_nw;
    int exp_first;
    int exp_last;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fill_rom(input int mode);
    for (int i = 0; i < 2048; i++) begin
      case (mode)
        0: rom_mem[i] = 5'd3;
        1: rom_mem[i] = 5'd0;
        2: rom_mem[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        default: rom_mem[i] = (i < W) ? 5'(i + 1) : 5'd3;
      endcase
    end
  endtask

  // Reference: every sprite pixel in raster order, kept if opaque and on screen.
  task automatic build_model(input int px, input int py, input bit mir);
    exp_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int x, y, d;
        x = px + c;
        y = py + r;
        d = int'(rom_mem[r * W + (mir ? (W - 1 - c) : c)]);
        if (d != 0 && x < FBW && y < FBH) exp_q.push_back('{addr: y * FBW + x, data: d});
      end
    end
  endtask

  task automatic run_blit(input int px, input int py, input bit mir, input bit hold,
                          output int nw, output int model_n, output int first_addr,
                          output int last_addr, output int first_data, output int lat,
                          output int busy_done, output int mism, output int busy_bad);
    build_model(px, py, mir);
    model_n = exp_q.size();
    nw = 0; first_addr = -1; last_addr = -1; first_data = -1;
    lat = -1; busy_done = -1; mism = 0; busy_bad = 0;
    bus.pos_x = 10'(px);
    bus.pos_y = 10'(py);
`ifdef BLIT_MIRROR_EN
    bus.mirror_x = mir;
`endif
    bus.start = 1'b1;
    @(posedge vga_clk);
    #1;
    if (!hold) bus.start = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge vga_clk);
      @(negedge vga_clk);
      if (bus.fb_we) begin
        if (nw == 0) begin
          first_addr = int'(bus.fb_addr);
          first_data = int'(bus.fb_data);
        end
        last_addr = int'(bus.fb_addr);
        nw++;
        if (exp_q.size() == 0) begin
          mism++;
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (e.addr != int'(bus.fb_addr) || e.data != int'(bus.fb_data)) begin
            if (mism == 0)
              $display("  first diff at write %0d: addr %0d data %0d, model addr %0d data %0d",
                       nw, bus.fb_addr, bus.fb_data, e.addr, e.data);
            mism++;
          end
        end
      end
      if (bus.done) begin
        lat = k;
        busy_done = int'(bus.busy);
        break;
      end
      if (int'(bus.busy) != ((k <= N + 2) ? 1 : 0)) busy_bad++;
    end
  endtask

  vec_t vecs[3];
  int nw, model_n, fa, la, fd, lat, bd, mism, bb;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{px: 0,   py: 0, mode: 0, exp_nw: 945, exp_first: 0,   exp_last: 14100};
    vecs[1] = '{px: 0,   py: 0, mode: 1, exp_nw: 0,   exp_first: -1,  exp_last: -1};
    vecs[2] = '{px: 310, py: 0, mode: 0, exp_nw: 450, exp_first: 310, exp_last: 14399};

    bus.start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
`ifdef BLIT_MIRROR_EN
    bus.mirror_x = 1'b0;
`endif
    fill_rom(1);
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;
    @(negedge vga_clk);
    check("reset rom_address", int'(bus.rom_address), 0);
    check("reset fb_we", int'(bus.fb_we), 0);
    check("reset fb_addr", int'(bus.fb_addr), 0);
    check("reset fb_data", int'(bus.fb_data), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);

    for (int v = 0; v < 3; v++) begin
      fill_rom(vecs[v].mode);
      @(negedge vga_clk);
      run_blit(vecs[v].px, vecs[v].py, 1'b0, 1'b0, nw, model_n, fa, la, fd, lat, bd, mism, bb);
      check($sformatf("vec%0d writes", v), nw, vecs[v].exp_nw);
      check($sformatf("vec%0d writes vs model", v), nw, model_n);
      check($sformatf("vec%0d first fb_addr", v), fa, vecs[v].exp_first);
      check($sformatf("vec%0d last fb_addr", v), la, vecs[v].exp_last);
      check($sformatf("vec%0d done cycle", v), lat, N + 3);
      check($sformatf("vec%0d busy at done", v), bd, 0);
      check($sformatf("vec%0d model diffs", v), mism, 0);
      check($sformatf("vec%0d busy window errors", v), bb, 0);
    end

    for (int t = 0; t < 4; t++) begin
      int px, py;
      fill_rom(2);
      px = int'($urandom_range(0, 340));
      py = int'($urandom_range(0, 250));
      @(negedge vga_clk);
      run_blit(px, py, 1'b0, 1'b0, nw, model_n, fa, la, fd, lat, bd, mism, bb);
      check($sformatf("rand%0d (%0d,%0d) writes vs model", t, px, py), nw, model_n);
      check($sformatf("rand%0d model diffs", t), mism, 0);
      check($sformatf("rand%0d done cycle", t), lat, N + 3);
    end

    // start held high across two back-to-back blits
    fill_rom(0);
    @(negedge vga_clk);
    for (int b = 0; b < 2; b++) begin
      run_blit(0, 0, 1'b0, 1'b1, nw, model_n, fa, la, fd, lat, bd, mism, bb);
      check($sformatf("held blit%0d writes", b), nw, 945);
      check($sformatf("held blit%0d done cycle", b), lat, N + 3);
      check($sformatf("held blit%0d model diffs", b), mism, 0);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge vga_clk);

    // reset in RUN at E0+100
    fill_rom(0);
    bus.pos_x = '0;
    bus.pos_y = '0;
    bus.start = 1'b1;
    @(posedge vga_clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge vga_clk);
      @(negedge vga_clk);
    end
    check("fb_we before mid-run reset", int'(bus.fb_we), 1);
    reset = 1'b1;
    @(posedge vga_clk);
    @(negedge vga_clk);
    check("fb_we after reset", int'(bus.fb_we), 0);
    check("busy after reset", int'(bus.busy), 0);
    check("done after reset", int'(bus.done), 0);
    check("rom_address after reset", int'(bus.rom_address), 0);
    reset = 1'b0;
    begin
      int wr_cnt, dn_cnt;
      wr_cnt = 0;
      dn_cnt = 0;
      for (int k = 0; k < 1100; k++) begin
        @(negedge vga_clk);
        if (bus.fb_we) wr_cnt++;
        if (bus.done || bus.busy) dn_cnt++;
      end
      check("writes after aborted blit", wr_cnt, 0);
      check("busy/done after aborted blit", dn_cnt, 0);
    end

`ifdef BLIT_MIRROR_EN
    fill_rom(3);
    @(negedge vga_clk);
    run_blit(0, 0, 1'b1, 1'b0, nw, model_n, fa, la, fd, lat, bd, mism, bb);
    check("mirror first fb_addr", fa, 0);
    check("mirror first fb_data", fd, 21);
    check("mirror model diffs", mism, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Copies one sprite from a palette-index sprite ROM into the palette-index frame-buffer RAM at a given screen position. It skips transparent pixels and clips at the frame edges. It is the writer side of the sprite image path: the per-pixel mappers and palettes later read back the indices it deposits. It sits between the game-logic controller, which issues start and position, and the frame-buffer write port, and runs at one pixel per clock.

## Interface
Parameters:
- SPRITE_W, 21: sprite width in pixels
- SPRITE_H, 45: sprite height in pixels
- FB_W, 320: frame-buffer width in pixels
- FB_H, 240: frame-buffer height in pixels
- IDX_W, 5: palette-index width
- ROM_AW, 11: sprite ROM address width
- FB_AW, 17: frame-buffer address width
- TRANSPARENT_IDX, 0: palette index that is never written

Ports:
- vga_clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a blit; sampled only in IDLE
- pos_x  in  10  sprite top-left X, latched on accepted start
- pos_y  in  10  sprite top-left Y, latched on accepted start
- rom_address  out  ROM_AW  sprite ROM address, registered
- rom_q  in  IDX_W  ROM data, valid one cycle after address
- fb_we  out  1  frame-buffer write enable, registered
- fb_addr  out  FB_AW  frame-buffer address, registered
- fb_data  out  IDX_W  palette index to write, registered
- busy  out  1  blit in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when start=1, latch pos_x/pos_y, clear col and row, and go to RUN.
- RUN: each cycle present rom_address = row*SPRITE_W + col, then advance col. Wrap col to 0 and increment row after col = SPRITE_W-1. After the address for (SPRITE_W-1, SPRITE_H-1), go to DRAIN.
- DRAIN: 2 cycles to flush the ROM and output pipeline, then go to DONE.
- DONE: assert done for 1 cycle, then go to IDLE.
- Write stage: a 2-entry pipeline carries (col, row) alongside the ROM read. When rom_q returns, set fb_data = rom_q and fb_addr = (pos_y+row)*FB_W + (pos_x+col).
- fb_we=1 only if rom_q ≠ TRANSPARENT_IDX, pos_x+col < FB_W and pos_y+row < FB_H. Clipping is checked at 11-bit width, so no wrap-around.
- Compute addresses incrementally with row-base accumulators (add SPRITE_W or FB_W per row). No multipliers.
- start outside IDLE is ignored. It is not queued.
- reset in any state: next edge goes to IDLE with fb_we=0, busy=0, done=0. Pipeline valids are cleared and the aborted blit issues no further writes.

## Timing
- Reset values: rom_address=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0.
- Start accepted at edge E0. The first rom_address is valid in cycle E0+1, rom_q in E0+2, and the first fb_we/fb_addr/fb_data in E0+3.
- Throughput is 1 pixel/cycle. The last write is visible in cycle E0+2+SPRITE_W*SPRITE_H.
- done pulses in the following cycle, E0+3+SPRITE_W*SPRITE_H. Default total is 948 cycles from start to done.
- busy is 1 from E0+1 through the last-write cycle and 0 in the done cycle. A new start may be accepted in the cycle after done.

## Configuration
- BLIT_MIRROR_EN defined:
  - Adds input port mirror_x (1 bit), latched with start.
  - When latched 1, the ROM column read is SPRITE_W-1-col while the write column stays col, giving a horizontal flip.
  - This allows one ROM per facing direction to be dropped.
- Undefined: no mirror_x port; the ROM column always equals col.

## Structure
- Package blit_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default SPRITE_W/H and FB_W/H
  - IDX_W and TRANSPARENT_IDX
- Sub-module blit_addr_gen: the col/row counters and incremental ROM/frame-buffer row-base accumulators, including the mirror column when enabled.
- Top level holds the FSM, pipeline valids, clipping and the output registers.

## Test plan
- ROM all index 3, pos (0,0), start pulse:
  - exactly 945 writes
  - first fb_addr 0, last fb_addr 14100
  - done in cycle E0+948, busy low there
- ROM all 0 (transparent), pos (0,0): zero fb_we; done still at E0+948.
- ROM all 3, pos_x=310, pos_y=0: writes only for columns 0–9 (450 writes); no fb_addr with X ≥ 320.
- start held high throughout a blit: a second blit begins only after done; exactly 945 writes per blit.
- reset asserted in RUN at E0+100: fb_we low from the next cycle; no writes until the next start; busy=0.
- BLIT_MIRROR_EN, ROM row 0 holding col index+1, mirror_x=1, pos (0,0): the write at fb_addr 0 carries data 21.
